// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_fetch_queue
//  Description : Instruction-fetch stage with a small prefetch queue. Issues
//                one outstanding req/ack fetch at a time, buffers fetched
//                words, drives the IF/ID register, and handles stall,
//                redirect and NOP bubble insertion.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_rdata,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic [31:0]                  ifid_ir,
    output logic [XLEN-1:0]              ifid_pc,
    output logic                         ifid_valid,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   C_FULL     = CW'(DEPTH);
    localparam logic [31:0]     C_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] C_STEP     = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN    = XLEN'(3);
    localparam logic [XLEN-1:0] C_PC_RESET = PC_RESET & ~C_ALIGN;

    // Fetch control state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            drop_q,     drop_d;
    logic [XLEN-1:0] pend_pc_q,  pend_pc_d;

    // Queue bookkeeping
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]   count_q,    count_d;

    // Queue storage (contents are qualified by count, so no reset is needed)
    logic [XLEN-1:0] ent_pc_q [DEPTH];
    logic [31:0]     ent_ir_q [DEPTH];

    // IF/ID register
    logic [31:0]     ifid_ir_q,    ifid_ir_d;
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic            ifid_valid_q, ifid_valid_d;

    logic            w_req;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redir_pc;

    // While a discarded response is still owed, the request must stay up even
    // if the queue bookkeeping says otherwise.
    assign w_req      = ~reset & (drop_q | (count_q != C_FULL));
    assign w_ack      = w_req & imem_ack;
    assign w_push     = w_ack & ~drop_q & ~redirect;
    assign w_pop      = ~redirect & ~stall & (count_q != '0);
    assign w_redir_pc = redirect_pc & ~C_ALIGN;

    assign imem_req    = w_req;
    assign imem_addr   = fetch_pc_q;
    assign ifid_ir     = ifid_ir_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign queue_count = count_q;

    // Next fetch address, drop tracking and pending redirect target
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        pend_pc_d  = pend_pc_q;
        if (redirect) begin
            if (w_req & ~imem_ack) begin
                // A request is outstanding: its address must not move, so
                // park the target until the stale response comes back.
                drop_d    = 1'b1;
                pend_pc_d = w_redir_pc;
            end else begin
                fetch_pc_d = w_redir_pc;
                drop_d     = 1'b0;
            end
        end else if (drop_q & w_ack) begin
            fetch_pc_d = pend_pc_q;
            drop_d     = 1'b0;
        end else if (w_push) begin
            fetch_pc_d = fetch_pc_q + C_STEP;
        end
    end

    // Queue pointers and occupancy
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // IF/ID register: pop the head, inject a NOP bubble, or hold on stall
    always_comb begin
        ifid_ir_d    = ifid_ir_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect) begin
            ifid_ir_d    = C_NOP;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            if (count_q != '0) begin
                ifid_ir_d    = ent_ir_q[rd_ptr_q];
                ifid_pc_d    = ent_pc_q[rd_ptr_q];
                ifid_valid_d = 1'b1;
            end else begin
                ifid_ir_d    = C_NOP;
                ifid_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= C_PC_RESET;
            drop_q       <= 1'b0;
            pend_pc_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ifid_ir_q    <= C_NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drop_q       <= drop_d;
            pend_pc_q    <= pend_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Queue storage write on an accepted response
    always_ff @(posedge clock) begin
        if (w_push) begin
            ent_pc_q[wr_ptr_q] <= fetch_pc_q;
            ent_ir_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
